// File: rtl/axi_burst_master.sv
// axi_burst_master
//   AXI4 master that turns cache refill / write-back requests into single
//   INCR bursts of one cache block (BLOCK_WORDS beats of DATA_WIDTH bits).
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   i_start_read/write    level requests from the cache FSMs (write wins)
//   i_read_addr/write_addr block-aligned burst addresses, latched at launch
//   i_wdata               cache word addressed by o_word_idx (comb lookup)
//   o_word_idx            beat index: read strobe index or current W beat
//   o_rdata, o_rdata_we   registered read beat and its one-cycle strobe
//   o_r_last, o_b_resp    one-cycle completion pulses (read / write)
//   o_resp_err            one-cycle pulse with completion if any response
//                         in the burst was not OKAY
//   AR/R/AW/W/B           AXI4 master channels
//   o_dbg_state           current FSM state for observation
//
// Handshake rule on every channel: a transfer happens in a cycle where both
// valid and ready are high. This master never drops a valid before its
// ready, and holds address/data stable while valid && !ready.
module axi_burst_master #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_start_read,
  input  logic                           i_start_write,
  input  logic [ADDR_WIDTH-1:0]          i_read_addr,
  input  logic [ADDR_WIDTH-1:0]          i_write_addr,
  input  logic [DATA_WIDTH-1:0]          i_wdata,
  output logic [$clog2(BLOCK_WORDS)-1:0] o_word_idx,
  output logic [DATA_WIDTH-1:0]          o_rdata,
  output logic                           o_rdata_we,
  output logic                           o_r_last,
  output logic                           o_b_resp,
  output logic                           o_resp_err,
  output logic                           o_ar_valid,
  input  logic                           i_ar_ready,
  output logic [ADDR_WIDTH-1:0]          o_ar_addr,
  output logic [7:0]                     o_ar_len,
  output logic [2:0]                     o_ar_size,
  output logic [1:0]                     o_ar_burst,
  input  logic                           i_r_valid,
  output logic                           o_r_ready,
  input  logic [DATA_WIDTH-1:0]          i_r_data,
  input  logic                           i_r_last,
  input  logic [1:0]                     i_r_resp,
  output logic                           o_aw_valid,
  input  logic                           i_aw_ready,
  output logic [ADDR_WIDTH-1:0]          o_aw_addr,
  output logic [7:0]                     o_aw_len,
  output logic [2:0]                     o_aw_size,
  output logic [1:0]                     o_aw_burst,
  output logic                           o_w_valid,
  input  logic                           i_w_ready,
  output logic [DATA_WIDTH-1:0]          o_w_data,
  output logic [DATA_WIDTH/8-1:0]        o_w_strb,
  output logic                           o_w_last,
  input  logic                           i_b_valid,
  output logic                           o_b_ready,
  input  logic [1:0]                     i_b_resp,
  output logic [2:0]                     o_dbg_state
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_WR   = 3'd3,
    S_B    = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        rd_idx_q, rd_idx_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    rdata_we_q, rdata_we_d;
  logic                    err_q, err_d;
  logic                    armed_q, armed_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;

  logic                    is_last;
  logic                    beat_bad;
  logic                    aw_ok;
  logic                    w_ok;

  // Constant burst shape.
  assign o_ar_len   = 8'(BLOCK_WORDS - 1);
  assign o_aw_len   = 8'(BLOCK_WORDS - 1);
  assign o_ar_size  = 3'($clog2(DATA_WIDTH / 8));
  assign o_aw_size  = 3'($clog2(DATA_WIDTH / 8));
  assign o_ar_burst = 2'b01;
  assign o_aw_burst = 2'b01;
  assign o_w_strb   = '1;
  assign o_ar_addr  = addr_q;
  assign o_aw_addr  = addr_q;
  assign o_w_data   = i_wdata;
  assign o_rdata    = rdata_q;
  assign o_rdata_we = rdata_we_q;
  assign o_dbg_state = state_q;

  // The counter has already advanced when a read strobe is shown, so the
  // strobe carries the index of the beat it belongs to.
  assign o_word_idx = rdata_we_q ? rd_idx_q : idx_q;

  assign is_last  = (idx_q == LAST_IDX);
  assign beat_bad = (i_r_resp != 2'b00) || (i_r_last != is_last);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    rd_idx_d   = rd_idx_q;
    rdata_d    = rdata_q;
    rdata_we_d = 1'b0;
    err_d      = err_q;
    armed_d    = armed_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    o_ar_valid = 1'b0;
    o_r_ready  = 1'b0;
    o_aw_valid = 1'b0;
    o_w_valid  = 1'b0;
    o_w_last   = 1'b0;
    o_b_ready  = 1'b0;
    o_r_last   = 1'b0;
    o_b_resp   = 1'b0;
    o_resp_err = 1'b0;
    aw_ok      = 1'b0;
    w_ok       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (armed_q && i_start_write) begin
          addr_d    = i_write_addr;
          armed_d   = 1'b0;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          idx_d     = '0;
          state_d   = S_WR;
        end else if (armed_q && i_start_read) begin
          addr_d  = i_read_addr;
          armed_d = 1'b0;
          err_d   = 1'b0;
          state_d = S_AR;
        end else if (!i_start_read && !i_start_write) begin
          // Re-arm only after the requester has dropped both starts.
          armed_d = 1'b1;
        end
      end

      S_AR: begin
        o_ar_valid = 1'b1;
        if (i_ar_ready) begin
          idx_d   = '0;
          state_d = S_R;
        end
      end

      S_R: begin
        o_r_ready = 1'b1;
        if (i_r_valid) begin
          rdata_d    = i_r_data;
          rdata_we_d = 1'b1;
          rd_idx_d   = idx_q;
          idx_d      = idx_q + 1'b1;
          if (beat_bad) begin
            err_d = 1'b1;
          end
          // Sequencing follows the internal count, not RLAST.
          if (is_last) begin
            o_r_last   = 1'b1;
            o_resp_err = err_q || beat_bad;
            state_d    = S_IDLE;
          end
        end
      end

      S_WR: begin
        o_aw_valid = !aw_done_q;
        o_w_valid  = !w_done_q;
        o_w_last   = !w_done_q && is_last;
        if (!aw_done_q && i_aw_ready) begin
          aw_done_d = 1'b1;
        end
        if (!w_done_q && i_w_ready) begin
          idx_d = idx_q + 1'b1;
          if (is_last) begin
            w_done_d = 1'b1;
          end
        end
        // AW and the last W beat may finish in either order or together.
        aw_ok = aw_done_q || i_aw_ready;
        w_ok  = w_done_q || (i_w_ready && is_last);
        if (aw_ok && w_ok) begin
          state_d = S_B;
        end
      end

      S_B: begin
        o_b_ready = 1'b1;
        if (i_b_valid) begin
          o_b_resp   = 1'b1;
          o_resp_err = (i_b_resp != 2'b00);
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      idx_q      <= '0;
      rd_idx_q   <= '0;
      rdata_q    <= '0;
      rdata_we_q <= 1'b0;
      err_q      <= 1'b0;
      armed_q    <= 1'b1;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      rd_idx_q   <= rd_idx_d;
      rdata_q    <= rdata_d;
      rdata_we_q <= rdata_we_d;
      err_q      <= err_d;
      armed_q    <= armed_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master
//   Bench for axi_burst_master: a randomizing AXI slave, a cache-buffer
//   array, and a transaction-level reference model that predicts every
//   output each cycle from launch/handshake bookkeeping.
module tb_axi_burst_master;

  localparam int AW = 64;
  localparam int DW = 32;
  localparam int BW = 16;
  localparam int IW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          i_start_read, i_start_write;
  logic [AW-1:0] i_read_addr, i_write_addr;
  logic [DW-1:0] i_wdata;
  logic [IW-1:0] o_word_idx;
  logic [DW-1:0] o_rdata;
  logic          o_rdata_we, o_r_last, o_b_resp, o_resp_err;
  logic          o_ar_valid, i_ar_ready;
  logic [AW-1:0] o_ar_addr;
  logic [7:0]    o_ar_len;
  logic [2:0]    o_ar_size;
  logic [1:0]    o_ar_burst;
  logic          i_r_valid, o_r_ready;
  logic [DW-1:0] i_r_data;
  logic          i_r_last;
  logic [1:0]    i_r_resp;
  logic          o_aw_valid, i_aw_ready;
  logic [AW-1:0] o_aw_addr;
  logic [7:0]    o_aw_len;
  logic [2:0]    o_aw_size;
  logic [1:0]    o_aw_burst;
  logic          o_w_valid, i_w_ready;
  logic [DW-1:0] o_w_data;
  logic [DW/8-1:0] o_w_strb;
  logic          o_w_last;
  logic          i_b_valid, o_b_ready;
  logic [1:0]    i_b_resp;
  logic [2:0]    o_dbg_state;

  logic [DW-1:0] wmem [BW];
  assign i_wdata = wmem[o_word_idx];

  axi_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WORDS(BW)) dut (
    .clk(clk), .rst(rst),
    .i_start_read(i_start_read), .i_start_write(i_start_write),
    .i_read_addr(i_read_addr), .i_write_addr(i_write_addr),
    .i_wdata(i_wdata), .o_word_idx(o_word_idx),
    .o_rdata(o_rdata), .o_rdata_we(o_rdata_we),
    .o_r_last(o_r_last), .o_b_resp(o_b_resp), .o_resp_err(o_resp_err),
    .o_ar_valid(o_ar_valid), .i_ar_ready(i_ar_ready), .o_ar_addr(o_ar_addr),
    .o_ar_len(o_ar_len), .o_ar_size(o_ar_size), .o_ar_burst(o_ar_burst),
    .i_r_valid(i_r_valid), .o_r_ready(o_r_ready), .i_r_data(i_r_data),
    .i_r_last(i_r_last), .i_r_resp(i_r_resp),
    .o_aw_valid(o_aw_valid), .i_aw_ready(i_aw_ready), .o_aw_addr(o_aw_addr),
    .o_aw_len(o_aw_len), .o_aw_size(o_aw_size), .o_aw_burst(o_aw_burst),
    .o_w_valid(o_w_valid), .i_w_ready(i_w_ready), .o_w_data(o_w_data),
    .o_w_strb(o_w_strb), .o_w_last(o_w_last),
    .i_b_valid(i_b_valid), .o_b_ready(o_b_ready), .i_b_resp(i_b_resp),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slave configuration ----------------
  int          cfg_ar_delay = 0, cfg_aw_delay = 0;
  int          cfg_ar_p = 100, cfg_aw_p = 100, cfg_r_p = 100, cfg_w_p = 100, cfg_b_p = 100;
  int          cfg_rerr_beat = -1, cfg_rlast_bad_beat = -1;
  logic [1:0]  cfg_rerr_resp = 2'b00, cfg_bresp = 2'b00;
  logic [DW-1:0] rd_tab [BW];

  // ---------------- AXI slave ----------------
  initial begin : slave
    logic s_rst, ar_v, aw_v, ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_seen;
    int   ar_wait, aw_wait, r_left, r_beat, w_cnt;
    ar_wait = 0; aw_wait = 0; r_left = 0; r_beat = 0; w_cnt = 0; aw_seen = 1'b0;
    i_ar_ready = 1'b0; i_r_valid = 1'b0; i_r_data = '0; i_r_last = 1'b0; i_r_resp = 2'b00;
    i_aw_ready = 1'b0; i_w_ready = 1'b0; i_b_valid = 1'b0; i_b_resp = 2'b00;
    forever begin
      @(negedge clk);
      s_rst = rst;
      ar_v  = o_ar_valid;
      aw_v  = o_aw_valid;
      ar_hs = o_ar_valid && i_ar_ready;
      r_hs  = o_r_ready && i_r_valid;
      aw_hs = o_aw_valid && i_aw_ready;
      w_hs  = o_w_valid && i_w_ready;
      b_hs  = o_b_ready && i_b_valid;
      @(posedge clk);
      #1;
      if (s_rst) begin
        ar_wait = 0; aw_wait = 0; r_left = 0; r_beat = 0; w_cnt = 0; aw_seen = 1'b0;
        i_ar_ready = 1'b0; i_r_valid = 1'b0; i_aw_ready = 1'b0; i_w_ready = 1'b0;
        i_b_valid = 1'b0;
      end else begin
        if (ar_hs) begin
          ar_wait = 0; r_left = BW; r_beat = 0;
        end else if (ar_v) begin
          ar_wait++;
        end
        i_ar_ready = (ar_wait >= cfg_ar_delay) && ($urandom_range(99, 0) < cfg_ar_p);
        if (r_hs) begin
          r_beat++; r_left--;
        end
        if (!(i_r_valid && !r_hs)) begin
          if (r_left > 0 && $urandom_range(99, 0) < cfg_r_p) begin
            i_r_valid = 1'b1;
            i_r_data  = rd_tab[r_beat];
            i_r_resp  = (r_beat == cfg_rerr_beat) ? cfg_rerr_resp : 2'b00;
            i_r_last  = (r_beat == BW - 1) ^ (r_beat == cfg_rlast_bad_beat);
          end else begin
            i_r_valid = 1'b0;
          end
        end
        if (aw_hs) begin
          aw_seen = 1'b1; aw_wait = 0;
        end else if (aw_v) begin
          aw_wait++;
        end
        i_aw_ready = (aw_wait >= cfg_aw_delay) && ($urandom_range(99, 0) < cfg_aw_p);
        if (w_hs) w_cnt++;
        i_w_ready = ($urandom_range(99, 0) < cfg_w_p);
        if (b_hs) begin
          aw_seen = 1'b0; w_cnt = 0; i_b_valid = 1'b0;
        end else if (!i_b_valid && aw_seen && w_cnt == BW && $urandom_range(99, 0) < cfg_b_p) begin
          i_b_valid = 1'b1;
          i_b_resp  = cfg_bresp;
        end
      end
    end
  end

  // ---------------- reference model + compare ----------------
  // Transaction view: one burst in flight, tracked by handshake counts.
  logic          m_busy = 1'b0, m_wr = 1'b0, m_armed = 1'b1, m_after_rst = 1'b0;
  logic          m_ar_done = 1'b0, m_aw_done = 1'b0, m_err = 1'b0, we_due = 1'b0;
  logic [AW-1:0] m_addr = '0;
  int            m_r_beats = 0, m_w_beats = 0;
  logic [IW+DW-1:0] exp_q[$];

  // Observations for literal checks.
  int            n_rlast = 0, n_bresp = 0, n_err = 0, n_err_rlast = 0, n_err_b = 0;
  int            n_we = 0, n_wlast = 0, wlast_beat = -1, n_aw_stall = 0;
  int            n_ar_hs = 0, n_aw_hs = 0;
  logic [DW-1:0] obs_data [BW];
  logic [DW-1:0] obs_w [BW];

  initial begin : compare
    logic e_ar_v, e_r_rdy, e_aw_v, e_w_v, e_b_rdy, r_hs, w_hs, b_hs, e_err;
    logic [IW+DW-1:0] e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_ar_v  = m_busy && !m_wr && !m_ar_done;
      e_r_rdy = m_busy && !m_wr && m_ar_done;
      e_aw_v  = m_busy && m_wr && !m_aw_done;
      e_w_v   = m_busy && m_wr && (m_w_beats < BW);
      e_b_rdy = m_busy && m_wr && m_aw_done && (m_w_beats == BW);
      if (m_after_rst) begin
        chk("post_reset_state", o_dbg_state, 0);
        chk("post_reset_rdata", o_rdata, 0);
        chk("post_reset_word_idx", o_word_idx, 0);
      end
      chk("ar_valid", o_ar_valid, e_ar_v);
      chk("r_ready", o_r_ready, e_r_rdy);
      chk("aw_valid", o_aw_valid, e_aw_v);
      chk("w_valid", o_w_valid, e_w_v);
      chk("b_ready", o_b_ready, e_b_rdy);
      if (e_ar_v) begin
        chk("ar_addr", o_ar_addr, m_addr);
        chk("ar_len", o_ar_len, BW - 1);
        chk("ar_size", o_ar_size, 2);
        chk("ar_burst", o_ar_burst, 1);
      end
      if (e_aw_v) begin
        chk("aw_addr", o_aw_addr, m_addr);
        chk("aw_len", o_aw_len, BW - 1);
        chk("aw_size", o_aw_size, 2);
        chk("aw_burst", o_aw_burst, 1);
      end
      if (e_w_v) begin
        chk("w_word_idx", o_word_idx, m_w_beats);
        chk("w_data", o_w_data, wmem[m_w_beats]);
        chk("w_last", o_w_last, m_w_beats == BW - 1);
        chk("w_strb", o_w_strb, 4'hF);
      end
      r_hs  = e_r_rdy && i_r_valid;
      w_hs  = e_w_v && i_w_ready;
      b_hs  = e_b_rdy && i_b_valid;
      e_err = (r_hs && m_r_beats == BW - 1 && (m_err || i_r_resp != 2'b00 || !i_r_last)) ||
              (b_hs && i_b_resp != 2'b00);
      chk("r_last", o_r_last, r_hs && m_r_beats == BW - 1);
      chk("b_resp", o_b_resp, b_hs);
      chk("resp_err", o_resp_err, e_err);
      chk("rdata_we", o_rdata_we, we_due);
      if (we_due && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_idx", o_word_idx, e[IW+DW-1:DW]);
        chk("rd_data", o_rdata, e[DW-1:0]);
      end
      // observations
      if (o_rdata_we) begin
        n_we++;
        obs_data[o_word_idx] = o_rdata;
      end
      if (o_r_last) n_rlast++;
      if (o_b_resp) n_bresp++;
      if (o_resp_err) n_err++;
      if (o_resp_err && o_r_last) n_err_rlast++;
      if (o_resp_err && o_b_resp) n_err_b++;
      if (o_aw_valid && !i_aw_ready) n_aw_stall++;
      if (o_ar_valid && i_ar_ready) n_ar_hs++;
      if (o_aw_valid && i_aw_ready) n_aw_hs++;
      if (w_hs) begin
        obs_w[m_w_beats] = o_w_data;
        if (o_w_last) begin
          n_wlast++;
          wlast_beat = m_w_beats;
        end
      end
      // model update for the coming edge
      m_after_rst = rst;
      if (rst) begin
        m_busy = 1'b0; m_armed = 1'b1; m_ar_done = 1'b0; m_aw_done = 1'b0;
        m_err = 1'b0; we_due = 1'b0; m_r_beats = 0; m_w_beats = 0;
        exp_q.delete();
      end else begin
        we_due = r_hs;
        if (!m_busy) begin
          if (m_armed && (i_start_write || i_start_read)) begin
            m_busy = 1'b1; m_wr = i_start_write; m_armed = 1'b0;
            m_addr = i_start_write ? i_write_addr : i_read_addr;
            m_ar_done = 1'b0; m_aw_done = 1'b0; m_err = 1'b0;
            m_r_beats = 0; m_w_beats = 0;
          end else if (!i_start_write && !i_start_read) begin
            m_armed = 1'b1;
          end
        end else begin
          if (e_ar_v && i_ar_ready) m_ar_done = 1'b1;
          if (e_aw_v && i_aw_ready) m_aw_done = 1'b1;
          if (w_hs) m_w_beats++;
          if (r_hs) begin
            exp_q.push_back({IW'(m_r_beats), i_r_data});
            if (i_r_resp != 2'b00 || i_r_last != (m_r_beats == BW - 1)) m_err = 1'b1;
            m_r_beats++;
            if (m_r_beats == BW) m_busy = 1'b0;
          end
          if (b_hs) m_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [AW-1:0] addr);
    repeat (2) tick();
    i_read_addr  = addr;
    i_start_read = 1'b1;
    tick();
    i_start_read = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] addr);
    repeat (2) tick();
    i_write_addr  = addr;
    i_start_write = 1'b1;
    tick();
    i_start_write = 1'b0;
  endtask

  task automatic wait_rlast(input int target, input int budget);
    int k = 0;
    while (n_rlast < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("rlast_seen_in_budget", n_rlast >= target, 1);
  endtask

  task automatic wait_bresp(input int target, input int budget);
    int k = 0;
    while (n_bresp < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("bresp_seen_in_budget", n_bresp >= target, 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int b_rl, b_br, b_er, b_we, b_st, b_ar, b_aw, k;
    i_start_read = 1'b0; i_start_write = 1'b0;
    i_read_addr = '0; i_write_addr = '0;
    for (int i = 0; i < BW; i++) begin
      wmem[i] = '0; rd_tab[i] = '0; obs_data[i] = '0; obs_w[i] = '0;
    end
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // 1: plain read, data = beat index
    for (int i = 0; i < BW; i++) rd_tab[i] = DW'(i);
    b_rl = n_rlast; b_we = n_we; b_er = n_err; b_ar = n_ar_hs;
    do_read(64'h8000_0040);
    wait_rlast(b_rl + 1, 200);
    tick();
    chk("t1_strobes", n_we - b_we, 16);
    chk("t1_rlast_count", n_rlast - b_rl, 1);
    chk("t1_ar_count", n_ar_hs - b_ar, 1);
    chk("t1_no_err", n_err - b_er, 0);
    for (int i = 0; i < BW; i++) chk("t1_data", obs_data[i], i);

    // 2: write with AW held off for 5 cycles
    for (int i = 0; i < BW; i++) wmem[i] = DW'(i * 4);
    cfg_aw_delay = 5;
    b_br = n_bresp; b_st = n_aw_stall; n_wlast = 0; wlast_beat = -1;
    do_write(64'h100);
    wait_bresp(b_br + 1, 200);
    tick();
    cfg_aw_delay = 0;
    chk("t2_aw_stall", n_aw_stall - b_st, 5);
    chk("t2_bresp_count", n_bresp - b_br, 1);
    chk("t2_wlast_count", n_wlast, 1);
    chk("t2_wlast_beat", wlast_beat, 15);
    chk("t2_w_beat1", obs_w[1], 32'd4);
    chk("t2_w_beat15", obs_w[15], 32'd60);

    // 3: both starts together -> write first, no read until re-request
    repeat (2) tick();
    b_ar = n_ar_hs; b_aw = n_aw_hs; b_br = n_bresp; b_rl = n_rlast;
    i_read_addr = 64'h2000; i_write_addr = 64'h3000;
    i_start_read = 1'b1; i_start_write = 1'b1;
    wait_bresp(b_br + 1, 200);
    repeat (4) tick();
    chk("t3_aw_once", n_aw_hs - b_aw, 1);
    chk("t3_no_ar_yet", n_ar_hs - b_ar, 0);
    i_start_read = 1'b0; i_start_write = 1'b0;
    do_read(64'h2000);
    wait_rlast(b_rl + 1, 200);
    tick();
    chk("t3_ar_after_rearm", n_ar_hs - b_ar, 1);

    // 4: error responses
    cfg_bresp = 2'b10;
    b_br = n_bresp; b_er = n_err_b;
    do_write(64'h4000);
    wait_bresp(b_br + 1, 200);
    tick();
    cfg_bresp = 2'b00;
    chk("t4_bresp_err", n_err_b - b_er, 1);
    cfg_rerr_beat = 7; cfg_rerr_resp = 2'b11;
    b_rl = n_rlast; b_er = n_err_rlast;
    do_read(64'h5000);
    wait_rlast(b_rl + 1, 200);
    tick();
    cfg_rerr_beat = -1;
    chk("t4_rresp_err", n_err_rlast - b_er, 1);
    cfg_rlast_bad_beat = 3;
    b_rl = n_rlast; b_er = n_err_rlast;
    do_read(64'h5040);
    wait_rlast(b_rl + 1, 200);
    tick();
    cfg_rlast_bad_beat = -1;
    chk("t4_rlast_mismatch_err", n_err_rlast - b_er, 1);

    // 5: random backpressure on every channel
    cfg_ar_p = 50; cfg_aw_p = 50; cfg_r_p = 50; cfg_w_p = 50; cfg_b_p = 50;
    for (int t = 0; t < 12; t++) begin
      b_rl = n_rlast; b_br = n_bresp;
      if ($urandom_range(1, 0) == 1) begin
        for (int i = 0; i < BW; i++) wmem[i] = $urandom;
        do_write({$urandom, $urandom} & ~64'h3F);
        wait_bresp(b_br + 1, 600);
      end else begin
        for (int i = 0; i < BW; i++) rd_tab[i] = $urandom;
        do_read({$urandom, $urandom} & ~64'h3F);
        wait_rlast(b_rl + 1, 600);
      end
      tick();
      chk("t5_one_completion", (n_rlast - b_rl) + (n_bresp - b_br), 1);
    end
    cfg_ar_p = 100; cfg_aw_p = 100; cfg_r_p = 100; cfg_w_p = 100; cfg_b_p = 100;

    // 6: reset at beat 8 of a read, then a clean read
    for (int i = 0; i < BW; i++) rd_tab[i] = DW'(32'hA0 + i);
    b_rl = n_rlast;
    do_read(64'h6000);
    k = 0;
    while (!(m_busy && !m_wr && m_r_beats == 8) && k < 100) begin
      tick();
      k++;
    end
    chk("t6_reached_beat8", m_r_beats, 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("t6_no_completion", n_rlast - b_rl, 0);
    b_we = n_we;
    do_read(64'h6000);
    wait_rlast(b_rl + 1, 200);
    tick();
    chk("t6_fresh_strobes", n_we - b_we, 16);
    chk("t6_fresh_last_data", obs_data[15], 32'hAF);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
